// File: rtl/apb4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : apb4_pkg                                                          |
// | Brief  : Shared types for the APB4 bridge/demux (FSM states, request).     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package apb4_pkg;

  localparam int c_apb_addr_max = 32;
  localparam int c_apb_data_max = 32;
  localparam int c_apb_strb_max = c_apb_data_max / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_e;

  // Sized for the widest supported bus; narrower instances use the low bits.
  typedef struct packed {
    logic [c_apb_addr_max-1:0] addr;
    logic                      write;
    logic [c_apb_data_max-1:0] wdata;
    logic [c_apb_strb_max-1:0] strb;
    logic [2:0]                prot;
  } apb4_req_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb4_intf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : apb4_intf                                                         |
// | Brief  : APB4 signal bundle with master/slave modports.                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface apb4_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb4_addr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : apb4_addr_decode                                                  |
// | Brief  : Combinational base/mask address decoder, lowest index wins.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module apb4_addr_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = 2,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE [NUM_SLAVES] = '{default: '0},
  parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK [NUM_SLAVES] = '{default: '0}
) (
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  output logic [NUM_SLAVES-1:0] o_sel_oh,
  output logic [IDX_W-1:0]      o_sel_idx,
  output logic                  o_hit
);

  // Scan high to low so the last match written is the lowest index.
  always_comb begin
    o_sel_oh  = '0;
    o_sel_idx = '0;
    o_hit     = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_paddr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        o_sel_oh    = '0;
        o_sel_oh[i] = 1'b1;
        o_sel_idx   = IDX_W'(i);
        o_hit       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb4_bridge_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : apb4_bridge_demux                                                 |
// | Brief  : Registered APB4 1-to-N demux with error and timeout responses.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module apb4_bridge_demux
  import apb4_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE [NUM_SLAVES] = '{default: '0},
  parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK [NUM_SLAVES] = '{default: '0},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic     clk_i,
  input  logic     rst_i,
  apb4_intf.slave  master_if,
  apb4_intf.master slave_if [NUM_SLAVES],
  output logic     timeout_o
);

  localparam int c_idx_w    = idx_width(NUM_SLAVES);
  localparam int c_strb_w   = DATA_WIDTH / 8;
  localparam int c_cnt_w    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int c_tmo_last = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  bridge_state_e           r_state;
  apb4_req_t               r_req;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic [NUM_SLAVES-1:0]   r_penable;
  logic [c_idx_w-1:0]      r_idx;
  logic [c_cnt_w-1:0]      r_cnt;
  logic                    r_m_pready;
  logic                    r_m_pslverr;
  logic [DATA_WIDTH-1:0]   r_m_prdata;
  logic                    r_timeout;

  logic [NUM_SLAVES-1:0]   w_sel_oh;
  logic [c_idx_w-1:0]      w_sel_idx;
  logic                    w_hit;
  logic [NUM_SLAVES-1:0]   w_s_pready;
  logic [NUM_SLAVES-1:0]   w_s_pslverr;
  logic [DATA_WIDTH-1:0]   w_s_prdata [NUM_SLAVES];
  logic                    w_pready;
  logic                    w_pslverr;
  logic [DATA_WIDTH-1:0]   w_prdata;
  logic                    w_tmo_hit;

  apb4_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (c_idx_w),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .i_paddr   (master_if.paddr),
    .o_sel_oh  (w_sel_oh),
    .o_sel_idx (w_sel_idx),
    .o_hit     (w_hit)
  );

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
    assign slave_if[g].psel    = r_psel[g];
    assign slave_if[g].penable = r_penable[g];
    assign slave_if[g].pwrite  = r_req.write;
    assign slave_if[g].paddr   = r_req.addr[ADDR_WIDTH-1:0];
    assign slave_if[g].pwdata  = r_req.wdata[DATA_WIDTH-1:0];
    assign slave_if[g].pstrb   = r_req.strb[c_strb_w-1:0];
    assign slave_if[g].pprot   = r_req.prot;
    assign w_s_pready[g]       = slave_if[g].pready;
    assign w_s_pslverr[g]      = slave_if[g].pslverr;
    assign w_s_prdata[g]       = slave_if[g].prdata;
  end

  assign w_pready  = w_s_pready[r_idx];
  assign w_pslverr = w_s_pslverr[r_idx];
  assign w_prdata  = w_s_prdata[r_idx];
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == c_cnt_w'(c_tmo_last));

  // A master that abandoned the transfer never sees the response.
  assign master_if.pready  = r_m_pready & master_if.psel;
  assign master_if.pslverr = r_m_pslverr;
  assign master_if.prdata  = r_m_prdata;
  assign timeout_o         = r_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_psel      <= '0;
      r_penable   <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_m_pready  <= 1'b0;
      r_m_pslverr <= 1'b0;
      r_m_prdata  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_m_pready <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (master_if.psel && !master_if.penable) begin
            r_req.addr  <= c_apb_addr_max'(master_if.paddr);
            r_req.write <= master_if.pwrite;
            r_req.wdata <= c_apb_data_max'(master_if.pwdata);
            r_req.strb  <= c_apb_strb_max'(master_if.pstrb);
            r_req.prot  <= master_if.pprot;
            r_idx       <= w_sel_idx;
            if (w_hit) begin
              r_psel  <= w_sel_oh;
              r_state <= ST_SETUP;
            end else begin
              r_m_pready  <= 1'b1;
              r_m_pslverr <= 1'b1;
              r_m_prdata  <= '0;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          r_penable <= r_psel;
          r_cnt     <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_pready) begin
            r_psel      <= '0;
            r_penable   <= '0;
            r_m_pready  <= 1'b1;
            r_m_pslverr <= w_pslverr;
            r_m_prdata  <= r_req.write ? '0 : w_prdata;
            r_state     <= ST_RESP;
          end else if (w_tmo_hit) begin
            r_psel      <= '0;
            r_penable   <= '0;
            r_timeout   <= 1'b1;
            r_m_pready  <= 1'b1;
            r_m_pslverr <= 1'b1;
            r_m_prdata  <= '0;
            r_state     <= ST_RESP;
          end else if (r_cnt != {c_cnt_w{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          // Response fields are only meaningful during the PREADY cycle.
          r_m_pslverr <= 1'b0;
          r_m_prdata  <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb4_bridge_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_apb4_bridge_demux                                              |
// | Brief  : Directed bench with a transfer-timeline model for the APB4 demux. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_apb4_bridge_demux;

  localparam int NS  = 4;
  localparam int TMO = 8;
  localparam logic [31:0] C_BASE [NS] = '{32'h1000_0000, 32'h1000_1000,
                                          32'h1000_2000, 32'h1000_3000};
  localparam logic [31:0] C_MASK [NS] = '{default: 32'hFFFF_F000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timeout;
  always #5 clk = ~clk;

  apb4_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();
  apb4_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if [NS] ();

  apb4_bridge_demux #(
    .NUM_SLAVES     (NS),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .SLAVE_BASE     (C_BASE),
    .SLAVE_MASK     (C_MASK),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .master_if (m_if),
    .slave_if  (s_if),
    .timeout_o (timeout)
  );

  // Slave behaviour knobs: wait states (-1 = never ready), read data, error.
  int          s_ws    [NS];
  logic [31:0] s_rdata [NS];
  logic        s_err   [NS];

  logic        w_psel  [NS];
  logic        w_pen   [NS];
  logic        w_pwr   [NS];
  logic [31:0] w_paddr [NS];
  logic [31:0] w_pwdat [NS];
  logic [3:0]  w_pstrb [NS];
  logic [2:0]  w_pprot [NS];

  for (genvar g = 0; g < NS; g++) begin : g_slv
    logic [3:0] cnt = '0;
    always @(posedge clk) begin
      if (s_if[g].psel && s_if[g].penable && !s_if[g].pready) cnt <= cnt + 4'd1;
      else                                                    cnt <= '0;
    end
    assign s_if[g].pready  = s_if[g].psel && s_if[g].penable && (s_ws[g] >= 0) && (int'(cnt) == s_ws[g]);
    assign s_if[g].prdata  = s_rdata[g];
    assign s_if[g].pslverr = s_err[g];
    assign w_psel[g]  = s_if[g].psel;
    assign w_pen[g]   = s_if[g].penable;
    assign w_pwr[g]   = s_if[g].pwrite;
    assign w_paddr[g] = s_if[g].paddr;
    assign w_pwdat[g] = s_if[g].pwdata;
    assign w_pstrb[g] = s_if[g].pstrb;
    assign w_pprot[g] = s_if[g].pprot;
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_tmo    = 0;
  bit chk_on   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (timeout) n_tmo <= n_tmo + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h cycle=%0d", nm, act, req, cyc);
    end
  endtask

  // Model of the transfer in flight: k = cycles since master SETUP; the
  // response cycle is k_end, slave phase covers 1..k_end-1.
  bit          m_act = 1'b0;
  int          m_t0, m_kend, m_slv;
  bit          m_hit, m_tmo;
  logic        m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic        m_err;

  task automatic model_start(input logic [31:0] a, input logic w, input logic [31:0] d);
    m_hit = 1'b0; m_slv = 0; m_tmo = 1'b0;
    for (int i = NS - 1; i >= 0; i--)
      if ((a & C_MASK[i]) == C_BASE[i]) begin m_hit = 1'b1; m_slv = i; end
    if (!m_hit)                                   m_kend = 1;
    else if (s_ws[m_slv] < 0 || s_ws[m_slv] >= TMO) begin m_kend = TMO + 2; m_tmo = 1'b1; end
    else                                          m_kend = 3 + s_ws[m_slv];
    m_err   = !m_hit || m_tmo || s_err[m_slv];
    m_rdata = (m_hit && !m_tmo && !w) ? s_rdata[m_slv] : 32'h0;
    m_addr  = a; m_write = w; m_wdata = d; m_strb = w ? 4'hF : 4'h0;
    m_t0    = cyc;
    m_act   = 1'b1;
    m_if.psel = 1'b1; m_if.penable = 1'b0; m_if.pwrite = w; m_if.paddr = a;
    m_if.pwdata = d; m_if.pstrb = m_strb; m_if.pprot = 3'b010;
  endtask

  always @(negedge clk) begin : p_cmp
    int k;
    bit inr, es;
    if (!rst && chk_on) begin
      k   = cyc - m_t0;
      inr = m_act && k >= 0 && k <= m_kend;
      for (int i = 0; i < NS; i++) begin
        es = inr && m_hit && (i == m_slv) && k >= 1 && k < m_kend;
        chk($sformatf("psel[%0d]", i), 32'(w_psel[i]), 32'(es));
        chk($sformatf("penable[%0d]", i), 32'(w_pen[i]), 32'(es && k >= 2));
        if (es) begin
          chk("paddr", w_paddr[i], m_addr);
          chk("pwrite", 32'(w_pwr[i]), 32'(m_write));
          chk("pwdata", w_pwdat[i], m_wdata);
          chk("pstrb", 32'(w_pstrb[i]), 32'(m_strb));
          chk("pprot", 32'(w_pprot[i]), 32'h2);
        end
      end
      chk("m_pready", 32'(m_if.pready), 32'(inr && k == m_kend));
      chk("m_prdata", m_if.prdata, (inr && k == m_kend) ? m_rdata : 32'h0);
      chk("m_pslverr", 32'(m_if.pslverr), 32'(inr && k == m_kend && m_err));
      chk("timeout_o", 32'(timeout), 32'(inr && k == m_kend && m_tmo));
    end
  end

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic er);
    model_start(a, w, d);
    @(posedge clk); #1 m_if.penable = 1'b1;
    lat = -1; rd = 'x; er = 1'bx;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (m_if.pready) begin
        lat = cyc - m_t0; rd = m_if.prdata; er = m_if.pslverr;
        break;
      end
    end
    if (lat < 0) chk("xfer_bound", 32'h0, 32'h1);
    @(posedge clk); #1;
    m_if.psel = 1'b0; m_if.penable = 1'b0;
  endtask

  int          lat, t_before;
  logic [31:0] rd;
  logic        er;

  initial begin
    for (int i = 0; i < NS; i++) begin s_ws[i] = 0; s_rdata[i] = 32'h0; s_err[i] = 1'b0; end
    m_if.psel = 1'b0; m_if.penable = 1'b0; m_if.pwrite = 1'b0; m_if.paddr = '0;
    m_if.pwdata = '0; m_if.pstrb = '0; m_if.pprot = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      chk("rst_psel", 32'(w_psel[i]), 32'h0);
      chk("rst_penable", 32'(w_pen[i]), 32'h0);
    end
    chk("rst_paddr", w_paddr[0], 32'h0);
    chk("rst_pwrite", 32'(w_pwr[0]), 32'h0);
    chk("rst_m_prdata", m_if.prdata, 32'h0);
    chk("rst_m_pslverr", 32'(m_if.pslverr), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    @(posedge clk); #1 rst = 1'b0; chk_on = 1'b1;

    // 1: zero-wait write to slave 2
    s_ws[2] = 0;
    xfer(32'h1000_2004, 1'b1, 32'hDEAD_BEEF, lat, rd, er);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_pslverr", 32'(er), 32'h0);
    chk("t1_prdata", rd, 32'h0);

    // 2: read with three wait states from slave 1
    s_ws[1] = 3; s_rdata[1] = 32'h1234_5678;
    xfer(32'h1000_1010, 1'b0, 32'h0, lat, rd, er);
    chk("t2_latency", 32'(lat), 32'd6);
    chk("t2_prdata", rd, 32'h1234_5678);

    // 3: unmapped read
    xfer(32'h2000_0000, 1'b0, 32'h0, lat, rd, er);
    chk("t3_latency", 32'(lat), 32'd1);
    chk("t3_pslverr", 32'(er), 32'h1);
    chk("t3_prdata", rd, 32'h0);

    // 4: hung slave 3 times out, then slave 0 works
    t_before = n_tmo;
    s_ws[3] = -1; s_rdata[3] = 32'hFFFF_0003;
    xfer(32'h1000_3000, 1'b0, 32'h0, lat, rd, er);
    chk("t4_latency", 32'(lat), 32'd10);
    chk("t4_pslverr", 32'(er), 32'h1);
    chk("t4_prdata", rd, 32'h0);
    s_ws[0] = 2; s_rdata[0] = 32'hA5A5_0001;
    xfer(32'h1000_0004, 1'b0, 32'h0, lat, rd, er);
    chk("t4_pulses", 32'(n_tmo - t_before), 32'd1);
    chk("t4b_latency", 32'(lat), 32'd5);
    chk("t4b_prdata", rd, 32'hA5A5_0001);

    // timeout boundary: 7 waits completes, 8 waits times out
    s_ws[3] = 7;
    xfer(32'h1000_3ffc, 1'b0, 32'h0, lat, rd, er);
    chk("b7_latency", 32'(lat), 32'd10);
    chk("b7_pslverr", 32'(er), 32'h0);
    chk("b7_prdata", rd, 32'hFFFF_0003);
    t_before = n_tmo;
    s_ws[3] = 8;
    xfer(32'h1000_3000, 1'b1, 32'h0000_0055, lat, rd, er);
    chk("b8_latency", 32'(lat), 32'd10);
    chk("b8_pslverr", 32'(er), 32'h1);
    chk("b8_pulses", 32'(n_tmo - t_before), 32'd1);

    // 5: slave error propagated on the response cycle only
    s_ws[0] = 1; s_err[0] = 1'b1;
    xfer(32'h1000_0008, 1'b1, 32'h0BAD_F00D, lat, rd, er);
    chk("t5_latency", 32'(lat), 32'd4);
    chk("t5_pslverr", 32'(er), 32'h1);
    s_err[0] = 1'b0;

    // 6: reset in the middle of a slave-1 ACCESS
    s_ws[1] = 5;
    model_start(32'h1000_1000, 1'b0, 32'h0);
    @(posedge clk); #1 m_if.penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 m_act = 1'b0; rst = 1'b1;
    #1;
    for (int i = 0; i < NS; i++) begin
      chk("t6_psel", 32'(w_psel[i]), 32'h0);
      chk("t6_penable", 32'(w_pen[i]), 32'h0);
    end
    chk("t6_m_pready", 32'(m_if.pready), 32'h0);
    m_if.psel = 1'b0; m_if.penable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    s_ws[2] = 0; s_ws[1] = 1; s_rdata[1] = 32'hCAFE_0101;
    xfer(32'h1000_2000, 1'b1, 32'h1111_2222, lat, rd, er);
    chk("t6a_latency", 32'(lat), 32'd3);
    xfer(32'h1000_1004, 1'b0, 32'h0, lat, rd, er);
    chk("t6b_latency", 32'(lat), 32'd4);
    chk("t6b_prdata", rd, 32'hCAFE_0101);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
